// File: rtl/tc_multi_pkg.sv
// Shared constants and types for the multi-channel timer/counter.
package tc_multi_pkg;

  // Default register window base on the peripheral bus.
  localparam logic [31:0] DevAddrBegin = 32'h1000_0000;

  // Address map.
  localparam int unsigned ChStride   = 'h10;
  localparam int unsigned StatOffset = 'h80;

  // Word index of each register inside a channel's stride.
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  // MODE encodings; anything other than reload behaves as one-shot.
  localparam logic [1:0] ModeOneShot = 2'b00;
  localparam logic [1:0] ModeReload  = 2'b01;

  // CTRL bit positions.
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlImBit   = 3;
  localparam int unsigned CtrlPscLsb  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount
  } ch_state_e;

  // Expand per-byte enables into a bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: control/preset registers, prescaler, down-counter and FSM.
module tc_channel
  import tc_multi_pkg::*;
#(
  parameter int unsigned CntW = 32,
  parameter int unsigned PscW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ctrl_we_i,
  input  logic            preset_we_i,
  input  logic [31:0]     wdata_i,
  input  logic            clr_i,
  output logic [31:0]     ctrl_o,
  output logic [CntW-1:0] preset_o,
  output logic [CntW-1:0] count_o,
  output logic            pending_o,
  output logic            im_o
);

  ch_state_e       state_q, state_d;
  logic            en_q, en_d;
  logic [1:0]      mode_q, mode_d;
  logic            im_q, im_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic [CntW-1:0] preset_q, preset_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PscW-1:0] psc_cnt_q, psc_cnt_d;
  logic            pending_q, pending_d;

  logic wr_en, wr_dis, tick, expire, reload;

  assign wr_en  = wdata_i[CtrlEnBit];
  // A bus write clearing EN freezes the channel before anything else happens.
  assign wr_dis = ctrl_we_i && !wr_en;
  assign tick   = (state_q == StCount) && (psc_cnt_q == psc_q);
  assign expire = tick && (count_q == '0) && !wr_dis;
  assign reload = (mode_q == ModeReload);

  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (wr_dis) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (ctrl_we_i && wr_en) state_d = StLoad;
        StLoad:  state_d = StCount;
        // A concurrent CTRL write (EN=1) overrides the one-shot EN clear, so keep counting.
        StCount: if (expire && !reload && !ctrl_we_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Register, prescaler, counter and pending next-state.
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    psc_d     = psc_q;
    preset_d  = preset_q;
    count_d   = count_q;
    psc_cnt_d = psc_cnt_q;

    if (ctrl_we_i) begin
      en_d   = wr_en;
      mode_d = wdata_i[CtrlModeLsb +: 2];
      im_d   = wdata_i[CtrlImBit];
      psc_d  = wdata_i[CtrlPscLsb +: PscW];
    end else if (expire && !reload) begin
      en_d = 1'b0;
    end

    if (preset_we_i) preset_d = wdata_i[CntW-1:0];

    if (!wr_dis) begin
      if (state_q == StLoad) begin
        count_d   = preset_q;
        psc_cnt_d = '0;
      end else if (state_q == StCount) begin
        if (tick) begin
          psc_cnt_d = '0;
          if (count_q != '0)  count_d = count_q - CntW'(1);
          else if (reload)    count_d = preset_q;
        end else begin
          psc_cnt_d = psc_cnt_q + PscW'(1);
        end
      end
    end

    // Set wins over a simultaneous write-1-to-clear.
    pending_d = expire | (pending_q & ~clr_i);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      mode_q    <= ModeOneShot;
      im_q      <= 1'b0;
      psc_q     <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      psc_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      psc_q     <= psc_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      psc_cnt_q <= psc_cnt_d;
      pending_q <= pending_d;
    end
  end

  // Outputs: CTRL readback with reserved bits at zero.
  always_comb begin
    ctrl_o                        = '0;
    ctrl_o[CtrlEnBit]             = en_q;
    ctrl_o[CtrlModeLsb +: 2]      = mode_q;
    ctrl_o[CtrlImBit]             = im_q;
    ctrl_o[CtrlPscLsb +: PscW]    = psc_q;
    preset_o                      = preset_q;
    count_o                       = count_q;
    pending_o                     = pending_q;
    im_o                          = im_q;
  end

endmodule

// File: rtl/tc_multi.sv
// Multi-channel bus timer/counter: address decode, byte merge, read mux and IRQ.
module tc_multi
  import tc_multi_pkg::*;
#(
  parameter logic [31:0] BASE  = DevAddrBegin,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    addr,
  input  logic           we,
  input  logic [3:0]     be,
  input  logic [31:0]    wd,
  output logic [31:0]    rd,
  output logic           irq,
  output logic [NCH-1:0] irq_vec
);

  logic [31:0]    offset;
  logic [2:0]     ch_sel;
  logic [1:0]     reg_sel;
  logic           ch_hit, stat_hit;
  logic [31:0]    mask;
  logic [NCH-1:0] stat_clr;
  logic [NCH-1:0] pending_vec, im_vec;

  logic [31:0] ctrl_rd   [NCH];
  logic [31:0] preset_rd [NCH];
  logic [31:0] count_rd  [NCH];

  assign offset   = addr - BASE;
  assign ch_sel   = offset[6:4];
  assign reg_sel  = offset[3:2];
  assign ch_hit   = (offset[31:7] == '0) && (32'(ch_sel) < NCH);
  assign stat_hit = (offset[31:2] == 30'(StatOffset >> 2));
  assign mask     = be_mask(be);
  assign stat_clr = (we && stat_hit) ? (wd[NCH-1:0] & mask[NCH-1:0]) : '0;

  logic unused_offset;
  assign unused_offset = ^offset[1:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic              sel;
    logic [31:0]       old_val;
    logic [31:0]       wdata;
    logic [CNT_W-1:0]  preset, count;

    assign sel     = we && ch_hit && (ch_sel == 3'(i));
    // Bytes not enabled keep the register's current contents.
    assign old_val = (reg_sel == RegCtrl) ? ctrl_rd[i] : preset_rd[i];
    assign wdata   = (old_val & ~mask) | (wd & mask);

    tc_channel #(
      .CntW (CNT_W),
      .PscW (PSC_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .ctrl_we_i   (sel && (reg_sel == RegCtrl)),
      .preset_we_i (sel && (reg_sel == RegPreset)),
      .wdata_i     (wdata),
      .clr_i       (stat_clr[i]),
      .ctrl_o      (ctrl_rd[i]),
      .preset_o    (preset),
      .count_o     (count),
      .pending_o   (pending_vec[i]),
      .im_o        (im_vec[i])
    );

    assign preset_rd[i] = 32'(preset);
    assign count_rd[i]  = 32'(count);
  end

  // Combinational read mux; unmapped and reserved offsets return zero.
  always_comb begin
    rd = '0;
    if (stat_hit) begin
      rd = 32'(pending_vec);
    end else if (ch_hit) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel == 3'(i)) begin
          case (reg_sel)
            RegCtrl:   rd = ctrl_rd[i];
            RegPreset: rd = preset_rd[i];
            RegCount:  rd = count_rd[i];
            default:   rd = '0;
          endcase
        end
      end
    end
  end

  // Level interrupt from registered pending and mask state.
  always_comb begin
    irq_vec = pending_vec & im_vec;
    irq     = |irq_vec;
  end

endmodule

// File: tb/tb_tc_multi.sv
// Directed self-checking bench for tc_multi (NCH=2, CNT_W=32, PSC_W=8).
module tb_tc_multi;

  localparam logic [31:0] Base = 32'h1000_0000;
  localparam logic [31:0] Ch0  = Base;
  localparam logic [31:0] Ch1  = Base + 32'h10;
  localparam logic [31:0] Stat = Base + 32'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic [1:0]  irq_vec;

  int checks = 0;
  int errors = 0;

  tc_multi #(
    .BASE  (Base),
    .NCH   (2),
    .CNT_W (32),
    .PSC_W (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .be      (be),
    .wd      (wd),
    .rd      (rd),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a;
    wd   = d;
    be   = b;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  initial begin
    reset = 1'b1;
    addr  = '0;
    we    = 1'b0;
    be    = '0;
    wd    = '0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check_rd("rst_ctrl0", Ch0, 32'h0);
    check_rd("rst_stat", Stat, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_vec", 32'(irq_vec), 32'h0);

    // One-shot, PRESET=5, PSC=0
    bus_wr(Ch0 + 4, 32'd5, 4'hf);
    bus_wr(Ch0, 32'h9, 4'hf);
    step();  // load edge
    for (int k = 0; k < 6; k++) begin
      check_rd("os_count", Ch0 + 8, 32'(5 - k));
      check_rd("os_stat_pre", Stat, 32'h0);
      step();
    end
    check_rd("os_stat", Stat, 32'h1);
    check("os_irq", 32'(irq), 32'h1);
    check_rd("os_ctrl", Ch0, 32'h8);
    check_rd("os_count_end", Ch0 + 8, 32'h0);
    bus_wr(Stat, 32'h1, 4'hf);
    check("os_irq_clr", 32'(irq), 32'h0);

    // Auto-reload with PSC=1 on ch1: expiry every 8 edges
    bus_wr(Ch1 + 4, 32'd3, 4'hf);
    bus_wr(Ch1, 32'h10B, 4'hf);
    step();  // load edge
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 4) check_rd("ar_count_mid", Ch1 + 8, 32'd1);
      if (n < 8) check_rd("ar_stat_pre", Stat, 32'h0);
    end
    check_rd("ar_stat", Stat, 32'h2);
    check_rd("ar_reload", Ch1 + 8, 32'd3);
    bus_wr(Stat, 32'h2, 4'hf);
    check("ar_irq_drop", 32'(irq), 32'h0);
    repeat (6) step();
    check_rd("ar_stat_gap", Stat, 32'h0);
    step();
    check_rd("ar_stat2", Stat, 32'h2);
    check("ar_irq2", 32'(irq), 32'h1);
    check("ar_irq_vec2", 32'(irq_vec), 32'h2);
    bus_wr(Ch1, 32'h0, 4'hf);
    bus_wr(Stat, 32'h2, 4'hf);

    // Byte enables and masking
    bus_wr(Ch0 + 4, 32'hAABBCCDD, 4'b0101);
    check_rd("be_preset", Ch0 + 4, 32'h00BB00DD);
    bus_wr(Ch0 + 8, 32'h1234, 4'hf);
    check_rd("ro_count", Ch0 + 8, 32'h0);
    check_rd("rsvd_c", Ch0 + 32'hC, 32'h0);
    check_rd("unmap_84", Base + 32'h84, 32'h0);
    check_rd("unmap_ch2", Base + 32'h20, 32'h0);
    bus_wr(Ch0, 32'hFFFF_FFFF, 4'b0000);
    check_rd("be_none", Ch0, 32'h8);
    bus_wr(Ch0, 32'hFFFF_FFFE, 4'hf);
    check_rd("ctrl_rsvd", Ch0, 32'h0000_FF0E);
    bus_wr(Ch0, 32'h8, 4'hf);

    // Set/clear collision, IM=0, PRESET=0 expires on first tick
    bus_wr(Ch0 + 4, 32'h0, 4'hf);
    bus_wr(Ch0, 32'h1, 4'hf);
    step();                        // load edge
    bus_wr(Stat, 32'h1, 4'hf);     // lands on expiry edge
    check_rd("col_stat", Stat, 32'h1);
    check("col_irq", 32'(irq), 32'h0);
    check("col_irq_vec", 32'(irq_vec), 32'h0);
    check_rd("col_ctrl", Ch0, 32'h0);
    bus_wr(Ch0, 32'h8, 4'hf);
    check("col_irq_im", 32'(irq), 32'h1);
    bus_wr(Stat, 32'h1, 4'hf);
    check("col_irq_clr", 32'(irq), 32'h0);

    // CTRL write on the expiry edge wins over the one-shot EN clear
    bus_wr(Ch0, 32'h1, 4'hf);
    step();
    bus_wr(Ch0, 32'h9, 4'hf);
    check_rd("bw_ctrl", Ch0, 32'h9);
    check_rd("bw_stat", Stat, 32'h1);
    bus_wr(Ch0, 32'h0, 4'hf);
    bus_wr(Stat, 32'h1, 4'hf);
    check_rd("bw_stat_clr", Stat, 32'h0);

    // Reset mid-count
    bus_wr(Ch0 + 4, 32'd10, 4'hf);
    bus_wr(Ch0, 32'h9, 4'hf);
    step();
    repeat (7) step();
    check_rd("mid_count", Ch0 + 8, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_rd("mr_ctrl", Ch0, 32'h0);
    check_rd("mr_preset", Ch0 + 4, 32'h0);
    check_rd("mr_count", Ch0 + 8, 32'h0);
    check("mr_irq", 32'(irq), 32'h0);
    repeat (15) step();
    check_rd("mr_stat", Stat, 32'h0);

    // Independence: ch0 P=2 (IM=1), ch1 P=4 (IM=0) started one edge apart
    bus_wr(Ch0 + 4, 32'd2, 4'hf);
    bus_wr(Ch1 + 4, 32'd4, 4'hf);
    bus_wr(Ch0, 32'h9, 4'hf);     // E0
    bus_wr(Ch1, 32'h1, 4'hf);     // E1: ch0 load
    step();                       // E2: ch1 load
    step();                       // E3
    check_rd("ind_stat_e3", Stat, 32'h0);
    step();                       // E4 = ch0 load + 3
    check_rd("ind_stat_e4", Stat, 32'h1);
    check("ind_vec_e4", 32'(irq_vec), 32'h1);
    repeat (2) step();            // E6
    check_rd("ind_stat_e6", Stat, 32'h1);
    step();                       // E7 = ch1 load + 5
    check_rd("ind_stat_e7", Stat, 32'h3);
    check("ind_vec_e7", 32'(irq_vec), 32'h1);
    check("ind_irq_e7", 32'(irq), 32'h1);
    bus_wr(Ch1, 32'h8, 4'hf);
    check("ind_vec_im", 32'(irq_vec), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
- Multi-channel, parametrised successor of the single-channel bus timer/counter.
- Sits on the CPU peripheral bus at a DEVn address window and exposes NCH independent down-counters.
- Each counter has a per-channel prescaler and one-shot or auto-reload mode.
- A shared write-1-to-clear interrupt status register feeds a single level IRQ to the CP0 interrupt line.

Parameters:
- BASE, `DEV0ADDR_BEGIN: byte address of the register window.
- NCH, 2: number of channels, 1..8.
- CNT_W, 32: counter/preset width, 8..32.
- PSC_W, 8: prescaler field width, 1..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr  in  32  bus byte address
- we  in  1  write strobe, qualified by the bus decoder
- be  in  4  byte enables for writes
- wd  in  32  write data
- rd  out  32  read data, combinational from addr
- irq  out  1  OR of pending & IM over all channels
- irq_vec  out  NCH  per-channel pending & IM

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Address map, offset = addr - BASE:
  - Channel i occupies 0x10*i.
  - +0x0 CTRL (RW): [0] EN, [2:1] MODE, [3] IM, [8+PSC_W-1:8] PSC.
  - +0x4 PRESET (RW, CNT_W bits).
  - +0x8 COUNT (RO).
  - +0xC reserved.
  - 0x80 STAT (bit i = pending i; write 1 clears).
- Register access rules:
  - Unmapped offsets and reserved bits read 0; writes to them are ignored.
  - Writes obey be per byte.
  - Values narrower than 32 bits are zero-extended on read and truncated on write.
- Reset: every CTRL, PRESET, COUNT, prescale counter and pending bit is 0; every state is IDLE; irq = 0, irq_vec = 0.
- Per-channel FSM:
  - IDLE: EN=0. COUNT holds its value.
  - LOAD: entered on the edge after a CTRL write takes EN from 0 to 1. On the next edge: COUNT <= PRESET, psc_cnt <= 0, go to COUNT.
  - COUNT: a tick occurs on an edge where psc_cnt == PSC; psc_cnt is reset to 0 on that edge, otherwise it increments.
    - On a tick with COUNT != 0: COUNT <= COUNT-1.
    - On a tick with COUNT == 0: expiry.
  - Writing EN=0 in any state goes to IDLE on that edge. COUNT freezes.
- Expiry:
  - Sets pending i, regardless of IM.
  - MODE 00 (and 1x, reserved): one-shot. Hardware clears EN and the FSM goes to IDLE; COUNT stays 0.
  - MODE 01: auto-reload. COUNT <= PRESET on the same edge; the FSM stays in COUNT.
- Latency: with PSC=0 and PRESET=P, pending is set P+1 edges after the LOAD->COUNT edge. With a general PSC, that becomes (P+1)*(PSC+1) edges.
- PRESET write while counting: no effect on COUNT until the next load or reload.
- PRESET=0: expiry on the first tick.
- Simultaneous events:
  - STAT W1C on the same edge as a set: the set wins and pending stays 1.
  - Bus write to CTRL on an expiry edge: the bus write wins for all CTRL bits, including EN.
  - CTRL write with EN=1 while already in COUNT does not reload.
- IRQ: irq and irq_vec are registered-state derived (pending & IM), not pulses. They stay high until STAT is cleared or IM is cleared.
- Reset mid-count: reset returns everything to the reset state on that edge and no expiry occurs.

Decomposition:
- Shared header macro.vh: register offsets (CTRL, PRESET, COUNT, STAT), MODE encodings, CTRL bit indices, channel stride 0x10, STAT offset 0x80.
- Sub-module tc_channel: FSM, prescaler, counter, expiry pulse. It takes decoded per-register write strobes, merged write data and W1C clear, and outputs count, ctrl, pending.
- tc_multi handles address decode, byte-enable merge, read mux and the IRQ OR-reduction, and instantiates NCH tc_channel.

Test Plan:
- One-shot: ch0 PRESET=5, CTRL=0x9 (EN, IM, MODE 00, PSC 0) -> COUNT reads 5,4,3,2,1,0. STAT=0x1 and irq=1 exactly 6 edges after the load edge. CTRL reads 0x8 (EN cleared).
- Auto-reload plus prescaler: ch1 PRESET=3, CTRL=0x10B (PSC=1, MODE 01, IM, EN) -> pending every 8 edges. After writing STAT=0x2, irq drops next edge and reasserts after 8 edges. COUNT never stalls.
- Byte enables and masking:
  - Write PRESET=0xAABBCCDD with be=0b0101 -> PRESET reads 0x00BB00DD.
  - COUNT write is ignored.
  - Offset 0xC and 0x84 read 0.
- Set/clear collision: drive a W1C of bit 0 on the exact expiry edge -> STAT bit 0 remains 1. IM=0 -> irq=0, STAT bit still 1.
- Reset mid-count: ch0 counting at COUNT=3, assert reset 1 cycle -> all reads 0, irq=0, no pending is set afterwards.
- Independence: NCH=2, ch0 PRESET=2 and ch1 PRESET=4 started the same cycle -> STAT 0x1 after 3 edges, 0x3 after 5. irq_vec follows IM per channel.
